// File: rtl/updown_seg7_counter_if.sv
// Button/clear inputs and count/segment/wrap outputs of one seven-segment counter group.
// The counter connects through the slave modport; the driver of the buttons uses master.
interface updown_seg7_counter_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    i_Up;
    logic                    i_Down;
    logic                    i_Clear;
    logic [4*NUM_DIGITS-1:0] o_Count;
    logic [7*NUM_DIGITS-1:0] o_Segments;
    logic                    o_Wrap;

    modport master (
        output i_Up, i_Down, i_Clear,
        input  o_Count, o_Segments, o_Wrap
    );

    modport slave (
        input  i_Up, i_Down, i_Clear,
        output o_Count, o_Segments, o_Wrap
    );
endinterface

// File: rtl/updown_seg7_counter.sv
// Multi-digit up/down counter with wrap limit, hex/decimal digits, hold-to-repeat,
// clear, and registered seven-segment decode.
module updown_seg7_counter #(
    parameter int NUM_DIGITS   = 2,
    parameter int RADIX_DEC    = 0,
    parameter int COUNT_MAX    = 255,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 2_500_000,
    parameter int SEG_ACT_LOW  = 1
) (
    input logic                 i_Clk,
    input logic                 i_Rst_L,
    updown_seg7_counter_if.slave bus
);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam int SW    = 7 * NUM_DIGITS;
    localparam int RADIX = (RADIX_DEC != 0) ? 10 : 16;
    localparam int CW    = ($clog2(COUNT_MAX + 1) < 1) ? 1 : $clog2(COUNT_MAX + 1);
    localparam int TMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW    = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

    localparam logic [CW-1:0] MAX_BIN    = CW'(COUNT_MAX);
    localparam logic [TW-1:0] DELAY_END  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_END   = TW'(REPEAT_RATE - 1);
    localparam logic [6:0]    SEG_ZERO   = (SEG_ACT_LOW != 0) ? 7'h01 : 7'h7E;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_e;

    function automatic logic [DW-1:0] digits_of(input int value);
        logic [DW-1:0] d;
        int            v;
        d = '0;
        v = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d[4*i +: 4] = 4'(v % RADIX);
            v = v / RADIX;
        end
        return d;
    endfunction

    localparam logic [DW-1:0] MAX_DIGITS = digits_of(COUNT_MAX);

    function automatic logic [DW-1:0] inc_digits(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic          carry;
        r     = d;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'(RADIX - 1)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] dec_digits(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic          borrow;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'(RADIX - 1);
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
        endcase
        // Out-of-range digits in decimal mode are blanked rather than shown as hex.
        if (RADIX_DEC != 0 && d > 4'd9) s = 7'h00;
        return (SEG_ACT_LOW != 0) ? ~s : s;
    endfunction

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_up_q, dir_up_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] bin_q, bin_d;
    logic [DW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;
    logic [SW-1:0] seg_q, seg_d;

    logic step, step_up, held, other;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_up_d = dir_up_q;
        // A button held through reset must be released before it can step again.
        armed_d  = armed_q | (~bus.i_Up & ~bus.i_Down);
        step     = 1'b0;
        step_up  = dir_up_q;
        held     = dir_up_q ? bus.i_Up   : bus.i_Down;
        other    = dir_up_q ? bus.i_Down : bus.i_Up;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (armed_q) begin
                    if (bus.i_Up && bus.i_Down) begin
                        state_d = LOCK;
                    end else if (bus.i_Up || bus.i_Down) begin
                        step     = 1'b1;
                        step_up  = bus.i_Up;
                        dir_up_d = bus.i_Up;
                        state_d  = DELAY;
                    end
                end
            end
            DELAY, REPEAT: begin
                if (other) begin
                    state_d = LOCK;
                    timer_d = '0;
                end else if (!held) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == ((state_q == DELAY) ? DELAY_END : RATE_END)) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOCK: begin
                timer_d = '0;
                if (!bus.i_Up && !bus.i_Down) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bin_d   = bin_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.i_Clear) begin
            bin_d   = '0;
            count_d = '0;
        end else if (step) begin
            if (step_up) begin
                if (bin_q == MAX_BIN) begin
                    bin_d   = '0;
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    bin_d   = bin_q + CW'(1);
                    count_d = inc_digits(count_q);
                end
            end else begin
                if (bin_q == '0) begin
                    bin_d   = MAX_BIN;
                    count_d = MAX_DIGITS;
                    wrap_d  = 1'b1;
                end else begin
                    bin_d   = bin_q - CW'(1);
                    count_d = dec_digits(count_q);
                end
            end
        end
    end

    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_d[7*i +: 7] = seg_decode(count_q[4*i +: 4]);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            dir_up_q <= 1'b1;
            armed_q  <= 1'b0;
            bin_q    <= '0;
            count_q  <= '0;
            wrap_q   <= 1'b0;
            seg_q    <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
            armed_q  <= armed_d;
            bin_q    <= bin_d;
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.o_Count    = count_q;
    assign bus.o_Segments = seg_q;
    assign bus.o_Wrap     = wrap_q;
endmodule

// File: tb/tb_updown_seg7_counter.sv
// Directed bench for updown_seg7_counter: decimal, 2 digits, limit 12, delay 8, rate 4.
module tb_updown_seg7_counter;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    updown_seg7_counter_if #(.NUM_DIGITS(2)) bus ();

    updown_seg7_counter #(
        .NUM_DIGITS  (2),
        .RADIX_DEC   (1),
        .COUNT_MAX   (12),
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4),
        .SEG_ACT_LOW (1)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // Active-low pin pattern for a decimal digit, {A..G} with A as MSB.
    function automatic logic [6:0] seg_pin(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'h7E;  1: s = 7'h30;  2: s = 7'h6D;  3: s = 7'h79;  4: s = 7'h33;
            5: s = 7'h5B;  6: s = 7'h5F;  7: s = 7'h70;  8: s = 7'h7F;  9: s = 7'h7B;
            default: s = 7'h00;
        endcase
        return ~s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn);
        bus.i_Up   = up;
        bus.i_Down = dn;
        tick();
        bus.i_Up   = 1'b0;
        bus.i_Down = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.i_Up    = 1'b0;
        bus.i_Down  = 1'b0;
        bus.i_Clear = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.o_Count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_count: got %h expected 00", bus.o_Count);
        end
        vectors++;
        if (bus.o_Wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wrap: got %b expected 0", bus.o_Wrap);
        end
        vectors++;
        if (bus.o_Segments !== ~{7'h7E, 7'h7E}) begin
            miscompares++;
            $display("FAIL reset_segments: got %h expected %h", bus.o_Segments, ~{7'h7E, 7'h7E});
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.o_Count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release_count: got %h expected 00", bus.o_Count);
        end
    endtask

    task automatic test_single_steps();
        for (int i = 1; i <= 3; i++) begin
            bus.i_Up = 1'b1;
            tick();
            bus.i_Up = 1'b0;
            vectors++;
            if (bus.o_Count !== 8'(i) || bus.o_Wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL step_count_%0d: got %h wrap %b expected %h wrap 0", i, bus.o_Count, bus.o_Wrap, 8'(i));
            end
            vectors++;
            if (bus.o_Segments !== {seg_pin(0), seg_pin(i - 1)}) begin
                miscompares++;
                $display("FAIL step_seg_early_%0d: got %h expected %h", i, bus.o_Segments, {seg_pin(0), seg_pin(i - 1)});
            end
            tick();
            vectors++;
            if (bus.o_Segments !== {seg_pin(0), seg_pin(i)}) begin
                miscompares++;
                $display("FAIL step_seg_%0d: got %h expected %h", i, bus.o_Segments, {seg_pin(0), seg_pin(i)});
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
        vectors++;
        if (bus.o_Count !== 8'h12) begin
            miscompares++;
            $display("FAIL wrap_preload: got %h expected 12", bus.o_Count);
        end
        bus.i_Up = 1'b1;
        tick();
        bus.i_Up = 1'b0;
        vectors++;
        if (bus.o_Count !== 8'h00 || bus.o_Wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_up: got %h wrap %b expected 00 wrap 1", bus.o_Count, bus.o_Wrap);
        end
        tick();
        vectors++;
        if (bus.o_Wrap !== 1'b0 || bus.o_Segments !== {seg_pin(0), seg_pin(0)}) begin
            miscompares++;
            $display("FAIL wrap_up_after: wrap %b seg %h expected wrap 0 seg %h", bus.o_Wrap, bus.o_Segments, {seg_pin(0), seg_pin(0)});
        end
        tick();
        bus.i_Down = 1'b1;
        tick();
        bus.i_Down = 1'b0;
        vectors++;
        if (bus.o_Count !== 8'h12 || bus.o_Wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_down: got %h wrap %b expected 12 wrap 1", bus.o_Count, bus.o_Wrap);
        end
        tick();
        vectors++;
        if (bus.o_Wrap !== 1'b0 || bus.o_Segments !== {seg_pin(1), seg_pin(2)}) begin
            miscompares++;
            $display("FAIL wrap_down_after: wrap %b seg %h expected wrap 0 seg %h", bus.o_Wrap, bus.o_Segments, {seg_pin(1), seg_pin(2)});
        end
        tick();
    endtask

    task automatic test_hold_repeat();
        int exp_cnt;
        pulse(1'b1, 1'b0);
        vectors++;
        if (bus.o_Count !== 8'h00) begin
            miscompares++;
            $display("FAIL hold_preload: got %h expected 00", bus.o_Count);
        end
        bus.i_Up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_cnt = int'(k >= 1) + int'(k >= 9) + int'(k >= 13) + int'(k >= 17);
            vectors++;
            if (bus.o_Count !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL hold_clock_%0d: got %h expected %h", k, bus.o_Count, 8'(exp_cnt));
            end
        end
        bus.i_Up = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (bus.o_Count !== 8'h04) begin
                miscompares++;
                $display("FAIL hold_release_%0d: got %h expected 04", k, bus.o_Count);
            end
        end
    endtask

    task automatic test_lock();
        bus.i_Up = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if (bus.o_Count !== 8'h05) begin
            miscompares++;
            $display("FAIL lock_first_step: got %h expected 05", bus.o_Count);
        end
        bus.i_Down = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (bus.o_Count !== 8'h05) begin
                miscompares++;
                $display("FAIL lock_both_%0d: got %h expected 05", k, bus.o_Count);
            end
        end
        bus.i_Up = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (bus.o_Count !== 8'h05) begin
                miscompares++;
                $display("FAIL lock_down_only_%0d: got %h expected 05", k, bus.o_Count);
            end
        end
        bus.i_Down = 1'b0;
        tick();
        bus.i_Down = 1'b1;
        tick();
        bus.i_Down = 1'b0;
        vectors++;
        if (bus.o_Count !== 8'h04) begin
            miscompares++;
            $display("FAIL lock_then_down: got %h expected 04", bus.o_Count);
        end
        tick();
        tick();
        vectors++;
        if (bus.o_Count !== 8'h04) begin
            miscompares++;
            $display("FAIL lock_single_down: got %h expected 04", bus.o_Count);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        vectors++;
        if (bus.o_Count !== 8'h07) begin
            miscompares++;
            $display("FAIL clear_preload: got %h expected 07", bus.o_Count);
        end
        bus.i_Up    = 1'b1;
        bus.i_Clear = 1'b1;
        tick();
        bus.i_Up    = 1'b0;
        bus.i_Clear = 1'b0;
        vectors++;
        if (bus.o_Count !== 8'h00 || bus.o_Wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_beats_step: got %h wrap %b expected 00 wrap 0", bus.o_Count, bus.o_Wrap);
        end
        tick();
        tick();
        pulse(1'b0, 1'b1);
        vectors++;
        if (bus.o_Count !== 8'h12) begin
            miscompares++;
            $display("FAIL clear_wrap_preload: got %h expected 12", bus.o_Count);
        end
        bus.i_Up    = 1'b1;
        bus.i_Clear = 1'b1;
        tick();
        bus.i_Up    = 1'b0;
        bus.i_Clear = 1'b0;
        vectors++;
        if (bus.o_Count !== 8'h00 || bus.o_Wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_beats_wrap: got %h wrap %b expected 00 wrap 0", bus.o_Count, bus.o_Wrap);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_repeat();
        bus.i_Up = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        vectors++;
        if (bus.o_Count !== 8'h02) begin
            miscompares++;
            $display("FAIL midrst_preload: got %h expected 02", bus.o_Count);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (bus.o_Count !== 8'h00 || bus.o_Wrap !== 1'b0 || bus.o_Segments !== {seg_pin(0), seg_pin(0)}) begin
            miscompares++;
            $display("FAIL midrst_state: got %h wrap %b seg %h expected 00 wrap 0 seg %h", bus.o_Count, bus.o_Wrap, bus.o_Segments, {seg_pin(0), seg_pin(0)});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (bus.o_Count !== 8'h00) begin
                miscompares++;
                $display("FAIL midrst_held_%0d: got %h expected 00", k, bus.o_Count);
            end
        end
        bus.i_Up = 1'b0;
        tick();
        bus.i_Up = 1'b1;
        tick();
        bus.i_Up = 1'b0;
        vectors++;
        if (bus.o_Count !== 8'h01) begin
            miscompares++;
            $display("FAIL midrst_repress: got %h expected 01", bus.o_Count);
        end
        tick();
        vectors++;
        if (bus.o_Segments !== {seg_pin(0), seg_pin(1)}) begin
            miscompares++;
            $display("FAIL midrst_repress_seg: got %h expected %h", bus.o_Segments, {seg_pin(0), seg_pin(1)});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.i_Up    = 1'b0;
        bus.i_Down  = 1'b0;
        bus.i_Clear = 1'b0;
        test_reset();
        test_single_steps();
        test_wrap();
        test_hold_repeat();
        test_lock();
        test_clear();
        test_reset_mid_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
